// File: rtl/ram_pkg.sv
// Shared types and default parameters for the synchronous RAM controller.
package ram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_W         = 12;
    localparam int unsigned DEF_DATA_W         = 4;
    localparam int unsigned DEF_READ_LAT       = 1;
    localparam int unsigned DEF_CLEAR_ON_RESET = 1;

    // Number of words addressed by an addr_w-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port word storage with a registered read that holds between reads.
module ram_array
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_sync_ctrl.sv
// Synchronous RAM controller: power-up clear sweep, valid/ready requests,
// pipelined reads with one or two cycles of latency.
module ram_sync_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned READ_LAT       = DEF_READ_LAT,
    parameter int unsigned CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] sweep_cnt;
    logic [ADDR_W-1:0] sweep_cnt_next;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic              rd_valid1;
    logic [DATA_W-1:0] rd_data1;

    // State, sweep counter, ready/done flags and first read-valid stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            sweep_cnt <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            rd_valid1 <= 1'b0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
            req_ready <= (state_next == IDLE);
            init_done <= (state_next == IDLE);
            rd_valid1 <= mem_re;
        end
    end

    // Next state and memory port steering; sweep owns the port in INIT.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_addr       = req_addr;
        mem_wdata      = req_wdata;

        unique case (state)
            INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_addr  = sweep_cnt;
                    mem_wdata = '0;
                    if (sweep_cnt == LAST_ADDR) begin
                        state_next = IDLE;
                    end else begin
                        sweep_cnt_next = sweep_cnt + ADDR_W'(1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (req_valid && req_ready) begin
                    mem_we = req_we;
                    mem_re = !req_we;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase

        // A reset edge must neither touch memory nor launch a read.
        if (reset) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rd_data1)
    );

    if (READ_LAT == 2) begin : g_lat2
        logic              rd_valid2;
        logic [DATA_W-1:0] rd_data2;

        // Second stage captures data only on a valid beat so it holds otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid2 <= 1'b0;
                rd_data2  <= '0;
            end else begin
                rd_valid2 <= rd_valid1;
                if (rd_valid1) begin
                    rd_data2 <= rd_data1;
                end
            end
        end

        assign rsp_valid = rd_valid2;
        assign rsp_rdata = rd_data2;
    end else begin : g_lat1
        assign rsp_valid = rd_valid1;
        assign rsp_rdata = rd_data1;
    end

endmodule

// File: tb/tb_ram_sync_ctrl.sv
// Directed bench for ram_sync_ctrl: three configurations, scoreboard-checked reads.
module tb_ram_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       reset     [3];
    logic       req_valid [3];
    logic       req_we    [3];
    logic [3:0] req_wdata [3];
    logic       req_ready [3];
    logic       rsp_valid [3];
    logic [3:0] rsp_rdata [3];
    logic       init_done [3];
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [11:0] addr_c;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] exp_q2[$];

    ram_sync_ctrl #(.ADDR_W(4), .DATA_W(4), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(addr_a), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0])
    );

    ram_sync_ctrl #(.ADDR_W(4), .DATA_W(4), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(addr_b), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1])
    );

    ram_sync_ctrl #(.ADDR_W(12), .DATA_W(4), .READ_LAT(1), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(addr_c), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .init_done(init_done[2])
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic we,
                         input logic [11:0] a, input logic [3:0] wd);
        req_valid[d] = v;
        req_we[d]    = we;
        req_wdata[d] = wd;
        case (d)
            0:       addr_a = a[3:0];
            1:       addr_b = a[3:0];
            default: addr_c = a;
        endcase
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 1'b0, 12'h000, 4'h0);
    endtask

    task automatic push(input int d, input logic [3:0] v);
        case (d)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    // Pop the oldest expected read for instance d and compare.
    task automatic check_rsp(input int d, input logic [3:0] data);
        logic [3:0] exp;
        int n;
        n = qsize(d);
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("FAIL rsp_unexpected[%0d]: observed rsp_valid=1 data %0h expected no response", d, data);
        end
        if (n > 0) begin
            case (d)
                0:       exp = exp_q0.pop_front();
                1:       exp = exp_q1.pop_front();
                default: exp = exp_q2.pop_front();
            endcase
            chk($sformatf("rsp_data[%0d]", d), 12'(data), 12'(exp));
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                check_rsp(d, rsp_rdata[d]);
            end
        end
    end

    // Sweep of 16 words: ready low through edge 15, high after edge 16.
    task automatic ready_seq(input int d);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("sweep_ready[%0d] k=%0d", d, k), 12'(req_ready[d]), 12'(k == 16));
            chk($sformatf("sweep_done[%0d] k=%0d", d, k), 12'(init_done[d]), 12'(k == 16));
            if (k == 15) begin
                idle(d);
            end
        end
    endtask

    initial begin
        addr_a = '0;
        addr_b = '0;
        addr_c = '0;
        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1;
            idle(d);
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready[%0d]", d), 12'(req_ready[d]), 12'(1'b0));
            chk($sformatf("rst_done[%0d]", d),  12'(init_done[d]), 12'(1'b0));
            chk($sformatf("rst_rvalid[%0d]", d), 12'(rsp_valid[d]), 12'(1'b0));
            chk($sformatf("rst_rdata[%0d]", d), 12'(rsp_rdata[d]), 12'h000);
        end

        // Instance a: write held through the sweep must be ignored.
        reset[0] = 1'b0;
        drive(0, 1'b1, 1'b1, 12'h003, 4'hF);
        ready_seq(0);
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b1, 1'b0, 12'(a), 4'h0);
            push(0, 4'h0);
            tick();
        end
        idle(0);
        tick();
        tick();
        drive(0, 1'b1, 1'b1, 12'h005, 4'hA);
        tick();
        drive(0, 1'b1, 1'b0, 12'h005, 4'h0);
        push(0, 4'hA);
        tick();
        chk("raw_rvalid", 12'(rsp_valid[0]), 12'(1'b1));
        chk("raw_rdata",  12'(rsp_rdata[0]), 12'h00A);
        idle(0);
        tick();
        chk("hold_rvalid", 12'(rsp_valid[0]), 12'(1'b0));
        chk("hold_rdata",  12'(rsp_rdata[0]), 12'h00A);

        // Instance b: read held through the sweep must not respond.
        reset[1] = 1'b0;
        drive(1, 1'b1, 1'b0, 12'h007, 4'h0);
        ready_seq(1);
        for (int a = 1; a <= 3; a++) begin
            drive(1, 1'b1, 1'b1, 12'(a), 4'(a));
            tick();
        end
        drive(1, 1'b1, 1'b0, 12'h001, 4'h0);
        push(1, 4'h1);
        tick();
        chk("lat2_early_rvalid", 12'(rsp_valid[1]), 12'(1'b0));
        drive(1, 1'b1, 1'b0, 12'h002, 4'h0);
        push(1, 4'h2);
        tick();
        chk("lat2_beat1_rvalid", 12'(rsp_valid[1]), 12'(1'b1));
        chk("lat2_beat1_rdata",  12'(rsp_rdata[1]), 12'h001);
        drive(1, 1'b1, 1'b0, 12'h003, 4'h0);
        push(1, 4'h3);
        tick();
        chk("lat2_beat2_rvalid", 12'(rsp_valid[1]), 12'(1'b1));
        chk("lat2_beat2_rdata",  12'(rsp_rdata[1]), 12'h002);
        idle(1);
        tick();
        chk("lat2_beat3_rvalid", 12'(rsp_valid[1]), 12'(1'b1));
        chk("lat2_beat3_rdata",  12'(rsp_rdata[1]), 12'h003);
        tick();
        chk("lat2_end_rvalid", 12'(rsp_valid[1]), 12'(1'b0));
        chk("lat2_end_rdata",  12'(rsp_rdata[1]), 12'h003);

        // Instance b: reset right after a read accept aborts the response.
        drive(1, 1'b1, 1'b0, 12'h002, 4'h0);
        tick();
        idle(1);
        reset[1] = 1'b1;
        tick();
        chk("abort_rvalid", 12'(rsp_valid[1]), 12'(1'b0));
        chk("abort_ready",  12'(req_ready[1]), 12'(1'b0));
        chk("abort_rdata",  12'(rsp_rdata[1]), 12'h000);
        reset[1] = 1'b0;
        ready_seq(1);
        for (int a = 0; a < 4; a++) begin
            drive(1, 1'b1, 1'b0, 12'(a), 4'h0);
            push(1, 4'h0);
            tick();
        end
        idle(1);
        tick();
        tick();
        tick();

        // Instance c: no clear, contents survive a reset pulse.
        reset[2] = 1'b0;
        tick();
        chk("noclr_ready", 12'(req_ready[2]), 12'(1'b1));
        chk("noclr_done",  12'(init_done[2]), 12'(1'b1));
        drive(2, 1'b1, 1'b1, 12'h3FF, 4'h7);
        tick();
        idle(2);
        reset[2] = 1'b1;
        tick();
        chk("noclr_rst_done", 12'(init_done[2]), 12'(1'b0));
        reset[2] = 1'b0;
        tick();
        chk("noclr_redone", 12'(init_done[2]), 12'(1'b1));
        drive(2, 1'b1, 1'b0, 12'h3FF, 4'h0);
        push(2, 4'h7);
        tick();
        chk("noclr_rvalid", 12'(rsp_valid[2]), 12'(1'b1));
        chk("noclr_rdata",  12'(rsp_rdata[2]), 12'h007);
        idle(2);
        tick();
        tick();

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("pending_rsp[%0d]", d), 12'(qsize(d)), 12'h000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
